// File: rtl/sr_pkg.sv
// Shared types and helpers for the clocked SR flop bank.
package sr_pkg;

   localparam int SR_MODE_W = 2;

   typedef enum logic [SR_MODE_W-1:0] {
      SR_HOLD       = 2'd0,
      SR_SET_WINS   = 2'd1,
      SR_RESET_WINS = 2'd2,
      SR_TOGGLE     = 2'd3
   } sr_mode_e;

   // Next state of one channel; the mode only matters when set and reset collide.
   function automatic logic sr_next(input logic q, input logic s, input logic r,
                                    input sr_mode_e mode);
      logic nxt;
      if (s && !r) begin
         nxt = 1'b1;
      end else if (!s && r) begin
         nxt = 1'b0;
      end else if (!s && !r) begin
         nxt = q;
      end else begin
         case (mode)
            SR_HOLD:       nxt = q;
            SR_SET_WINS:   nxt = 1'b1;
            SR_RESET_WINS: nxt = 1'b0;
            SR_TOGGLE:     nxt = ~q;
            default:       nxt = q;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sr_sync.sv
// N-bit, DEPTH-stage flop synchroniser; collapses to plain wires when DEPTH is 0.
module sr_sync #(
   parameter int N     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign q = d;
      end else begin : g_chain
         logic [N-1:0] stage_r [DEPTH];

         // Shift chain; every stage clears on reset so in-flight requests are dropped.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < DEPTH; k++) begin
                  stage_r[k] <= {N{1'b0}};
               end
            end else begin
               stage_r[0] <= d;
               for (int k = 1; k < DEPTH; k++) begin
                  stage_r[k] <= stage_r[k-1];
               end
            end
         end

         assign q = stage_r[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of WIDTH clocked SR channels with optional input synchronisers,
// selectable S=R=1 rule, change pulses and sticky conflict flags.
module sr_flop_bank
   import sr_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b0}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [SR_MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]     S,
   input  logic [WIDTH-1:0]     R,
   input  logic [WIDTH-1:0]     clr_conflict,
   output logic [WIDTH-1:0]     Q,
   output logic [WIDTH-1:0]     Qbar,
   output logic [WIDTH-1:0]     changed,
   output logic [WIDTH-1:0]     conflict
);

   logic [WIDTH-1:0] s_s;
   logic [WIDTH-1:0] r_s;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] qbar_r;
   logic [WIDTH-1:0] q_d_r;
   logic [WIDTH-1:0] changed_r;
   logic [WIDTH-1:0] conflict_r;
   logic [WIDTH-1:0] q_next_s;
   logic [WIDTH-1:0] changed_next_s;
   logic [WIDTH-1:0] conflict_next_s;
   sr_mode_e         mode_s;

   sr_sync #(.N(WIDTH), .DEPTH(SYNC_STAGES)) u_sync_s (
      .clk (clk),
      .rst (rst),
      .d   (S),
      .q   (s_s)
   );

   sr_sync #(.N(WIDTH), .DEPTH(SYNC_STAGES)) u_sync_r (
      .clk (clk),
      .rst (rst),
      .d   (R),
      .q   (r_s)
   );

   assign mode_s = sr_mode_e'(mode);

   // Per-channel next state; with en low the synchronised requests are discarded.
   always_comb begin
      q_next_s        = q_r;
      changed_next_s  = {WIDTH{1'b0}};
      conflict_next_s = conflict_r;
      if (en) begin
         for (int i = 0; i < WIDTH; i++) begin
            q_next_s[i] = sr_next(q_r[i], s_s[i], r_s[i], mode_s);
         end
         changed_next_s  = q_r ^ q_d_r;
         conflict_next_s = (s_s & r_s) | (conflict_r & ~clr_conflict);
      end else begin
         q_next_s        = q_r;
         changed_next_s  = {WIDTH{1'b0}};
         conflict_next_s = conflict_r;
      end
   end

   // State and flag registers; q_d_r mirrors Q one edge late so reset release never pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_r        <= INIT;
         qbar_r     <= ~INIT;
         q_d_r      <= INIT;
         changed_r  <= {WIDTH{1'b0}};
         conflict_r <= {WIDTH{1'b0}};
      end else begin
         q_r        <= q_next_s;
         qbar_r     <= ~q_next_s;
         q_d_r      <= q_r;
         changed_r  <= changed_next_s;
         conflict_r <= conflict_next_s;
      end
   end

   assign Q        = q_r;
   assign Qbar     = qbar_r;
   assign changed  = changed_r;
   assign conflict = conflict_r;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Self-checking bench: two banks (2-stage and no synchroniser) against a behavioural model.
module tb_sr_flop_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b1;
   logic [1:0] mode = 2'd0;
   logic [7:0] S = 8'h00;
   logic [7:0] R = 8'h00;
   logic [7:0] clr = 8'h00;

   logic [7:0] qa, qba, ca, fa;
   logic [7:0] qb, qbb, cb, fb;

   int nvec = 0;
   int nerr = 0;

   sr_flop_bank #(.WIDTH(8), .SYNC_STAGES(2), .INIT(8'hA5)) dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .S(S), .R(R),
      .clr_conflict(clr), .Q(qa), .Qbar(qba), .changed(ca), .conflict(fa)
   );

   sr_flop_bank #(.WIDTH(8), .SYNC_STAGES(0), .INIT(8'h00)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .S(S), .R(R),
      .clr_conflict(clr), .Q(qb), .Qbar(qbb), .changed(cb), .conflict(fb)
   );

   always #5 clk = ~clk;

   // Model state: index 0 is the 2-stage bank, index 1 the unsynchronised bank.
   logic [7:0] mq [2];
   logic [7:0] mchg [2];
   logic [7:0] mconf [2];
   logic [7:0] mdiff [2];
   logic [7:0] hs [3];
   logic [7:0] hr [3];
   logic [7:0] minit [2];

   function automatic logic rule(input logic q, input logic s, input logic r, input logic [1:0] m);
      if (s != r) return s;
      if (!s) return q;
      if (m == 2'd1) return 1'b1;
      if (m == 2'd2) return 1'b0;
      if (m == 2'd3) return ~q;
      return q;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Behavioural reference: core sees the request from SYNC_STAGES edges earlier.
   initial begin
      logic [7:0] es, er, nq;
      minit[0] = 8'hA5;
      minit[1] = 8'h00;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            for (int k = 0; k < 3; k++) begin
               hs[k] = 8'h00;
               hr[k] = 8'h00;
            end
            for (int d = 0; d < 2; d++) begin
               mq[d] = minit[d];
               mchg[d] = 8'h00;
               mconf[d] = 8'h00;
               mdiff[d] = 8'h00;
            end
         end else begin
            hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = S;
            hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = R;
            for (int d = 0; d < 2; d++) begin
               es = (d == 0) ? hs[2] : hs[0];
               er = (d == 0) ? hr[2] : hr[0];
               if (en) begin
                  mchg[d] = mdiff[d];
                  for (int b = 0; b < 8; b++) nq[b] = rule(mq[d][b], es[b], er[b], mode);
                  mconf[d] = (es & er) | (mconf[d] & ~clr);
                  mdiff[d] = nq ^ mq[d];
                  mq[d] = nq;
               end else begin
                  mchg[d] = 8'h00;
                  mdiff[d] = 8'h00;
               end
            end
         end
      end
   end

   // Every-cycle comparison of both banks against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("a_q", qa, mq[0]);
         chk("a_qbar", qba, ~mq[0]);
         chk("a_changed", ca, mchg[0]);
         chk("a_conflict", fa, mconf[0]);
         chk("b_q", qb, mq[1]);
         chk("b_qbar", qbb, ~mq[1]);
         chk("b_changed", cb, mchg[1]);
         chk("b_conflict", fb, mconf[1]);
      end
   end

   initial begin
      #1 rst = 1'b1;
      step(2);
      chk("rst_q", qa, 8'hA5);
      chk("rst_qbar", qba, 8'h5A);
      chk("rst_chg", ca, 8'h00);
      chk("rst_conf", fa, 8'h00);
      rst = 1'b0;
      step(3);
      chk("release_chg", ca, 8'h00);
      chk("release_q", qa, 8'hA5);

      // Latency: clear bit 0, then a one-cycle set pulse.
      R = 8'h01; step(1); R = 8'h00; step(4);
      chk("lat_clr_q", qa, 8'hA4);
      S = 8'h01; step(1); S = 8'h00;
      chk("lat_e1", qa, 8'hA4);
      step(1); chk("lat_e2", qa, 8'hA4);
      step(1); chk("lat_e3_q", qa, 8'hA5); chk("lat_e3_chg", ca, 8'h00);
      step(1); chk("lat_e4_chg", ca, 8'h01);
      step(1); chk("lat_e5_chg", ca, 8'h00); chk("lat_e5_q", qa, 8'hA5);

      // Collision rules on bit 3.
      mode = 2'd0; S = 8'h08; R = 8'h08; step(4); S = 8'h00; R = 8'h00; step(3);
      chk("hold_q", qa, 8'hA5);
      chk("hold_conf", fa, 8'h08);
      mode = 2'd1; S = 8'h08; R = 8'h08; step(4); S = 8'h00; R = 8'h00; step(3);
      chk("setwins_q", qa, 8'hAD);
      mode = 2'd2; S = 8'h08; R = 8'h08; step(4); S = 8'h00; R = 8'h00; step(3);
      chk("resetwins_q", qa, 8'hA5);
      mode = 2'd3; S = 8'h08; R = 8'h08; step(2);
      chk("tog_e2", qa, 8'hA5);
      step(1); chk("tog_e3", qa, 8'hAD);
      step(1); chk("tog_e4", qa, 8'hA5); chk("tog_e4_chg", ca, 8'h08);
      S = 8'h00; R = 8'h00;
      step(1); chk("tog_e5", qa, 8'hAD); chk("tog_e5_chg", ca, 8'h08);
      step(1); chk("tog_e6", qa, 8'hA5); chk("tog_e6_chg", ca, 8'h08);
      step(1); chk("tog_e7_chg", ca, 8'h08);
      step(1); chk("tog_e8_chg", ca, 8'h00);
      mode = 2'd0;
      clr = 8'h08; step(1); clr = 8'h00;
      chk("clr_bit3", fa, 8'h00);

      // Sticky conflict, clear, and clear losing to a coincident conflict.
      S = 8'h01; R = 8'h01; step(1); S = 8'h00; R = 8'h00; step(3);
      chk("conf_set", fa, 8'h01);
      step(2); chk("conf_sticky", fa, 8'h01);
      clr = 8'h01; step(1); clr = 8'h00;
      chk("conf_clr", fa, 8'h00);
      S = 8'h01; R = 8'h01; step(1); S = 8'h00; R = 8'h00; step(1);
      clr = 8'h01; step(1); clr = 8'h00;
      chk("conf_set_wins", fa, 8'h01);

      // Enable low discards requests that drain through the synchroniser.
      en = 1'b0; S = 8'hFF; step(1); S = 8'h00; step(4);
      chk("en0_q", qa, 8'hA5);
      chk("en0_chg", ca, 8'h00);
      chk("en0_conf", fa, 8'h01);
      en = 1'b1; step(3);
      chk("en1_q", qa, 8'hA5);
      chk("en1_chg", ca, 8'h00);

      // Reset mid-run takes effect without waiting for a clock.
      for (int k = 0; k < 5; k++) begin
         S = 8'($urandom_range(0, 255)); R = 8'($urandom_range(0, 255));
         mode = 2'($urandom_range(0, 3));
         step(1);
      end
      rst = 1'b1;
      #1;
      chk("mid_rst_q", qa, 8'hA5);
      chk("mid_rst_qbar", qba, 8'h5A);
      chk("mid_rst_chg", ca, 8'h00);
      chk("mid_rst_conf", fa, 8'h00);
      chk("mid_rst_qb", qb, 8'h00);
      S = 8'h00; R = 8'h00; mode = 2'd0;
      step(2);
      rst = 1'b0;
      step(3);
      chk("mid_rel_chg_a", ca, 8'h00);
      chk("mid_rel_chg_b", cb, 8'h00);
      chk("mid_rel_q", qa, 8'hA5);

      // Unsynchronised bank: independent channels, immediate response.
      S = 8'h0F; R = 8'hF0; step(1);
      chk("b_ind_q1", qb, 8'h0F);
      S = 8'hF0; R = 8'h0F; step(1);
      chk("b_ind_q2", qb, 8'hF0);
      chk("b_ind_chg1", cb, 8'h0F);
      S = 8'h00; R = 8'h00; step(1);
      chk("b_ind_chg2", cb, 8'hFF);

      // Randomised traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         S    = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
         R    = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
         clr  = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
         mode = 2'($urandom_range(0, 3));
         en   = ($urandom_range(0, 9) != 0);
         rst  = ($urandom_range(0, 199) == 0);
         step(1);
      end
      rst = 1'b0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
